sprite_line_engine: RTL and testbench
=====================================

SPRITE_LINE_ENGINE -- requirements
Module: sprite_line_engine

Interface
REQ-001 SHALL have parameter CORDW, default 11, signed coordinate width (bits).
REQ-002 SHALL have parameter WIDTH, default 8, sprite width in source pixels.
REQ-003 SHALL have parameter HEIGHT, default 8, sprite height in source lines.
REQ-004 SHALL have parameter SCALE_LOG2, default 0, scale factor of 2^SCALE_LOG2 in both axes.
REQ-005 SHALL have parameter COLRW, default 4, colour index width.
REQ-006 SHALL have parameter TRANSP, default 0, transparent colour index.
REQ-007 SHALL have parameter ADDRW, default 6, sprite memory address width (>= clog2(WIDTH*HEIGHT)).
REQ-008 clk_pix  input  1  pixel clock; the only clock.
REQ-009 rst_pix  input  1  reset; synchronous, active-high.
REQ-010 line  input  1  start-of-line pulse from display timing, high for one cycle at sx = horizontal start (blanking).
REQ-011 sx, sy  input  CORDW signed  current screen position.
REQ-012 sprx, spry  input  CORDW signed  sprite top-left position; sampled only on line pulse.
REQ-013 pos  output  ADDRW  sprite memory read address.
REQ-014 data_in  input  COLRW  sprite memory read data, valid exactly one cycle after pos.
REQ-015 pix  output  COLRW  sprite colour index for current pixel.
REQ-016 drawing  output  1  high when pix is an opaque sprite pixel.

Function
REQ-017 SHALL implement states IDLE, FETCH, WAIT, DRAW.
REQ-018 line high in any state SHALL sample sprx/spry and evaluate dy = sy - spry; if 0 <= dy < HEIGHT<<SCALE_LOG2, go to FETCH with row = dy>>SCALE_LOG2; otherwise go to IDLE; any fetch/draw in progress is abandoned.
REQ-019 FETCH SHALL drive pos = row*WIDTH + col for col = 0..WIDTH-1 on consecutive cycles, and SHALL write data_in into an internal line buffer entry col one cycle after that address.
REQ-020 FETCH SHALL last WIDTH+1 cycles (address issue plus one-cycle read latency), then go to WAIT.
REQ-021 WAIT SHALL go to DRAW on the cycle sx == sprx (sampled value); if that cycle has passed, no drawing on this line.
REQ-022 DRAW SHALL output buffer[col] for 2^SCALE_LOG2 consecutive cycles per col, col 0..WIDTH-1, then return to IDLE after WIDTH<<SCALE_LOG2 cycles.
REQ-023 pix/drawing SHALL be registered; the output for screen position sx appears one cycle after sx is presented (latency 1).
REQ-024 drawing SHALL be high only for DRAW-state pixels whose colour != TRANSP; pix SHALL be 0 whenever drawing is low.
REQ-025 Horizontal clipping is not performed; drawing is independent of data enable (downstream masks blanking).
REQ-026 Sprite positions with sprx earlier than line-position + WIDTH + 2 cycles SHALL not draw on that line (fetch not complete).
REQ-027 Arithmetic on dy SHALL be signed CORDW+1 bits, no wrap; sprites partially above/below screen draw only their visible rows.
REQ-028 pos SHALL hold its last value outside FETCH.

Reset
REQ-029 rst_pix SHALL force state IDLE, pos 0, pix 0, drawing 0, col and scale counters 0, and takes priority over line in the same cycle.
REQ-030 Line buffer contents need not be reset; no pixel is drawn before a complete FETCH.

Verification
REQ-031 800x600 timing, sprx=100, spry=50, WIDTH=8, SCALE_LOG2=0, row 0 = 1..8 -> line sy=50: pos 0..7 issued after line; drawing high at output cycles for sx=100..107 with pix 1..8.
REQ-032 Same, sy=49 and sy=58 -> no FETCH, drawing low whole line; sy=57 -> pos 56..63.
REQ-033 SCALE_LOG2=1, spry=50 -> sy=50,51 both fetch row 0, sy=52 row 1; each pixel repeated 2 cycles, sx=100..115.
REQ-034 Row containing TRANSP (0) at col 3 -> drawing low at sx=103, pix 0; neighbours drawn.
REQ-035 rst_pix asserted mid-DRAW at sx=103 -> drawing/pix 0 next cycle, no drawing until next valid line pulse.
REQ-036 line pulse arriving while in FETCH/WAIT (forced early) -> previous line abandoned, fetch restarts with new row, pos restarts at row*WIDTH.

Source files
------------

// File: rtl/sprite_line_engine.sv
// sprite_line_engine
//   Per-line hardware sprite. On each start-of-line pulse it decides whether
//   the current screen line crosses the sprite. If it does, it reads one sprite
//   row from an external synchronous memory into a small line buffer. It then
//   waits for the sprite's horizontal start and streams the row out, each
//   source pixel repeated 2^SCALE_LOG2 times.
//
// Ports
//   clk_pix  in   pixel clock (only clock)
//   rst_pix  in   synchronous active-high reset
//   line     in   one-cycle start-of-line pulse (horizontal blanking)
//   sx, sy   in   signed current screen position
//   sprx     in   signed sprite left edge, captured on line
//   spry     in   signed sprite top edge, used on line
//   pos      out  sprite memory read address (holds outside fetch)
//   data_in  in   sprite memory data, one cycle after pos
//   pix      out  colour index, registered (latency 1 from sx)
//   drawing  out  high while pix is an opaque sprite pixel
module sprite_line_engine #(
  parameter int CORDW      = 11,
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 8,
  parameter int SCALE_LOG2 = 0,
  parameter int COLRW      = 4,
  parameter int TRANSP     = 0,
  parameter int ADDRW      = 6
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix,
  input  logic                    line,
  input  logic signed [CORDW-1:0] sx,
  input  logic signed [CORDW-1:0] sy,
  input  logic signed [CORDW-1:0] sprx,
  input  logic signed [CORDW-1:0] spry,
  output logic [ADDRW-1:0]        pos,
  input  logic [COLRW-1:0]        data_in,
  output logic [COLRW-1:0]        pix,
  output logic                    drawing
);

  // Column counter must reach WIDTH during fetch (the extra read-latency cycle).
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int SW = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;

  localparam logic signed [CORDW:0] HLIM        = (CORDW+1)'(HEIGHT << SCALE_LOG2);
  localparam logic [SW-1:0]         SMAX        = SW'((1 << SCALE_LOG2) - 1);
  localparam logic [CW-1:0]         COL_FETCH_END = CW'(WIDTH);
  localparam logic [CW-1:0]         COL_LAST    = CW'(WIDTH - 1);
  localparam logic [COLRW-1:0]      TRANSP_C    = COLRW'(TRANSP);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRAW} state_t;

  state_t                  state_reg,   state_next;
  logic [CW-1:0]           col_reg,     col_next;
  logic [SW-1:0]           scl_reg,     scl_next;
  logic [RW-1:0]           row_reg,     row_next;
  logic signed [CORDW-1:0] sprx_reg,    sprx_next;
  logic [ADDRW-1:0]        pos_reg,     pos_next;
  logic [COLRW-1:0]        pix_reg,     pix_next;
  logic                    drawing_reg, drawing_next;

  logic [COLRW-1:0] line_buf [WIDTH];
  logic             buf_we;
  logic [BW-1:0]    buf_waddr;
  logic [COLRW-1:0] buf_rd;
  logic             buf_opaque;

  // Vertical offset one bit wider than the coordinates so that widely
  // separated sy/spry cannot wrap into the sprite's row range.
  logic signed [CORDW:0] dy;
  logic                  dy_in_range;
  logic [RW-1:0]         new_row;
  logic [ADDRW-1:0]      row_base;

  assign dy          = {sy[CORDW-1], sy} - {spry[CORDW-1], spry};
  assign dy_in_range = !dy[CORDW] && (dy < HLIM);
  assign new_row     = RW'(dy >>> SCALE_LOG2);
  assign row_base    = ADDRW'(int'(new_row) * WIDTH);

  assign buf_rd     = line_buf[BW'(col_reg)];
  assign buf_opaque = (buf_rd != TRANSP_C);

  always_comb begin
    state_next   = state_reg;
    col_next     = col_reg;
    scl_next     = scl_reg;
    row_next     = row_reg;
    sprx_next    = sprx_reg;
    pos_next     = pos_reg;
    pix_next     = '0;
    drawing_next = 1'b0;
    buf_we       = 1'b0;
    buf_waddr    = BW'(col_reg - 1'b1);

    if (line) begin
      // A new line always wins: whatever was in flight is dropped.
      sprx_next = sprx;
      col_next  = '0;
      scl_next  = '0;
      if (dy_in_range) begin
        state_next = FETCH;
        row_next   = new_row;
        pos_next   = row_base;
      end else begin
        state_next = IDLE;
      end
    end else begin
      case (state_reg)
        IDLE: begin
        end
        FETCH: begin
          // Address for column c is on pos during fetch cycle c; its data
          // arrives in cycle c+1 and is written to entry c.
          buf_we = (col_reg != '0);
          if (col_reg == COL_FETCH_END) begin
            state_next = WAIT;
            col_next   = '0;
          end else begin
            col_next = col_reg + 1'b1;
            if (col_reg < COL_LAST) begin
              pos_next = pos_reg + 1'b1;
            end
          end
        end
        WAIT, DRAW: begin
          // The cycle where sx reaches the sprite edge already produces the
          // first pixel, so the registered output lines up with sx.
          if (state_reg == DRAW || sx == sprx_reg) begin
            drawing_next = buf_opaque;
            pix_next     = buf_opaque ? buf_rd : '0;
            state_next   = DRAW;
            if (scl_reg == SMAX) begin
              scl_next = '0;
              if (col_reg == COL_LAST) begin
                state_next = IDLE;
                col_next   = '0;
              end else begin
                col_next = col_reg + 1'b1;
              end
            end else begin
              scl_next = scl_reg + 1'b1;
            end
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state_reg   <= IDLE;
      col_reg     <= '0;
      scl_reg     <= '0;
      row_reg     <= '0;
      sprx_reg    <= '0;
      pos_reg     <= '0;
      pix_reg     <= '0;
      drawing_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      col_reg     <= col_next;
      scl_reg     <= scl_next;
      row_reg     <= row_next;
      sprx_reg    <= sprx_next;
      pos_reg     <= pos_next;
      pix_reg     <= pix_next;
      drawing_reg <= drawing_next;
    end
  end

  // Line buffer is never read before a full fetch has refilled it, so it
  // carries no reset.
  always_ff @(posedge clk_pix) begin
    if (buf_we) begin
      line_buf[buf_waddr] <= data_in;
    end
  end

  assign pos     = pos_reg;
  assign pix     = pix_reg;
  assign drawing = drawing_reg;

endmodule

// File: tb/tb_sprite_line_engine.sv
// tb_sprite_line_engine
//   Drives two engines (scale 1x and 2x) from the same compressed display
//   timing (sx runs -16..255, line pulse at sx=-16) and shared sprite memory.
//   Every cycle is compared against a reference computed directly from the
//   sprite geometry. Table rows also carry hand-derived counts of drawn pixels.
module tb_sprite_line_engine;

  localparam int LSTART = -16;
  localparam int NCYC   = 272;
  localparam int W      = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_pix;
  logic              line;
  logic signed [10:0] sx, sy, sprx, spry;
  logic [5:0]        pos_a [2];
  logic [3:0]        din_a [2];
  logic [3:0]        pix_a [2];
  logic              drw_a [2];
  logic [3:0]        mem   [64];

  int checks = 0;
  int errors = 0;
  int pos_exp [2];

  typedef struct {
    int sy, sprx, spry, rst_j, j2, sy2, nd0, nd1;
  } vec_t;
  vec_t tbl [15];

  // Synchronous sprite memory: one cycle of read latency.
  always @(posedge clk) begin
    din_a[0] <= mem[pos_a[0]];
    din_a[1] <= mem[pos_a[1]];
  end

  sprite_line_engine #(.CORDW(11), .WIDTH(8), .HEIGHT(8), .SCALE_LOG2(0),
                       .COLRW(4), .TRANSP(0), .ADDRW(6)) dut0 (
    .clk_pix(clk), .rst_pix(rst_pix), .line(line), .sx(sx), .sy(sy),
    .sprx(sprx), .spry(spry), .pos(pos_a[0]), .data_in(din_a[0]),
    .pix(pix_a[0]), .drawing(drw_a[0]));

  sprite_line_engine #(.CORDW(11), .WIDTH(8), .HEIGHT(8), .SCALE_LOG2(1),
                       .COLRW(4), .TRANSP(0), .ADDRW(6)) dut1 (
    .clk_pix(clk), .rst_pix(rst_pix), .line(line), .sx(sx), .sy(sy),
    .sprx(sprx), .spry(spry), .pos(pos_a[1]), .data_in(din_a[1]),
    .pix(pix_a[1]), .drawing(drw_a[1]));

  task automatic check(input string name, input int d, input int idx,
                       input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s dut%0d idx%0d: got %0d, expected %0d", name, d, idx, got, exp);
    end
  endtask

  // Colour seen at screen x for a line whose pulse came at ls_sx, or 0.
  function automatic int exp_pix(input int s, input int lsy, input int spr_x,
                                 input int spr_y, input int ls_sx, input int x);
    int dy, off;
    dy = lsy - spr_y;
    if (dy < 0 || dy >= (8 << s)) return 0;
    if (spr_x < ls_sx + W + 2) return 0;
    off = x - spr_x;
    if (off < 0 || off >= (W << s)) return 0;
    return int'(mem[(dy >> s) * W + (off >> s)]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One display line. rst_j / j2 are cycle indices for a reset or a second
  // (early) line pulse carrying sy2; -1 disables them.
  task automatic run_line(input int sy_a, input int sprx_a, input int spry_a,
                          input int rst_j, input int j2, input int sy2,
                          output int nd0, output int nd1);
    int ls, lsy, e, dy;
    bit rs;
    int nd [2];
    nd[0] = 0; nd[1] = 0;
    ls = 0; lsy = sy_a; rs = 1'b0;
    for (int j = 0; j < NCYC; j++) begin
      if (j == j2) begin
        ls  = j;
        lsy = sy2;
      end
      sx      = 11'(LSTART + j);
      sy      = 11'(lsy);
      sprx    = 11'(sprx_a);
      spry    = 11'(spry_a);
      line    = (j == 0) || (j == j2);
      rst_pix = (j == rst_j);
      if (j == rst_j) rs = 1'b1;
      tick();
      for (int d = 0; d < 2; d++) begin
        if (rs) begin
          e = 0;
          pos_exp[d] = 0;
        end else begin
          e  = exp_pix(d, lsy, sprx_a, spry_a, LSTART + ls, LSTART + j);
          dy = lsy - spry_a;
          if (dy >= 0 && dy < (8 << d))
            pos_exp[d] = (dy >> d) * W + (((j - ls) < 7) ? (j - ls) : 7);
        end
        check("pixel", d, j, int'({drw_a[d], pix_a[d]}), (e != 0) ? 16 + e : 0);
        check("pos", d, j, int'(pos_a[d]), pos_exp[d]);
        if (drw_a[d]) nd[d]++;
      end
    end
    line    = 1'b0;
    rst_pix = 1'b0;
    nd0 = nd[0];
    nd1 = nd[1];
  endtask

  initial begin
    int nd0, nd1;
    //          sy     sprx  spry  rst_j j2  sy2 nd0 nd1
    tbl[0]  = '{50,    100,  50,   -1,   -1, 0,  8,  16};
    tbl[1]  = '{49,    100,  50,   -1,   -1, 0,  0,  0};
    tbl[2]  = '{58,    100,  50,   -1,   -1, 0,  0,  16};
    tbl[3]  = '{57,    100,  50,   -1,   -1, 0,  8,  16};
    tbl[4]  = '{51,    100,  50,   -1,   -1, 0,  8,  16};
    tbl[5]  = '{52,    100,  50,   -1,   -1, 0,  8,  16};
    tbl[6]  = '{50,    -7,   50,   -1,   -1, 0,  0,  0};
    tbl[7]  = '{50,    -6,   50,   -1,   -1, 0,  8,  16};
    tbl[8]  = '{2,     37,   -3,   -1,   -1, 0,  8,  16};
    tbl[9]  = '{50,    100,  50,   -1,   4,  52, 8,  16};
    tbl[10] = '{50,    100,  50,   -1,   4,  70, 0,  0};
    tbl[11] = '{50,    100,  50,   119,  -1, 0,  3,  3};
    tbl[12] = '{50,    100,  50,   -1,   -1, 0,  8,  16};
    tbl[13] = '{-1020, 100,  1020, -1,   -1, 0,  0,  0};
    tbl[14] = '{50,    100,  50,   0,    -1, 0,  0,  0};

    // Row 0 holds 1..8; no entry is transparent.
    for (int i = 0; i < 64; i++) mem[i] = 4'((i % 15) + 1);
    pos_exp[0] = 0; pos_exp[1] = 0;
    line = 1'b0; sx = '0; sy = '0; sprx = '0; spry = '0;

    rst_pix = 1'b1;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check("rst_pix", d, 0, int'(pix_a[d]), 0);
      check("rst_drawing", d, 0, int'(drw_a[d]), 0);
      check("rst_pos", d, 0, int'(pos_a[d]), 0);
    end
    rst_pix = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) begin
      run_line(tbl[i].sy, tbl[i].sprx, tbl[i].spry, tbl[i].rst_j,
               tbl[i].j2, tbl[i].sy2, nd0, nd1);
      check("ndraw", 0, i, nd0, tbl[i].nd0);
      check("ndraw", 1, i, nd1, tbl[i].nd1);
      $display("vector %0d: sy=%0d sprx=%0d spry=%0d drawn %0d/%0d", i,
               tbl[i].sy, tbl[i].sprx, tbl[i].spry, nd0, nd1);
    end

    // Transparent pixel at column 3 of row 0.
    mem[3] = 4'd0;
    run_line(50, 100, 50, -1, -1, 0, nd0, nd1);
    check("transp_ndraw", 0, 0, nd0, 7);
    check("transp_ndraw", 1, 0, nd1, 14);
    $display("transparent col3: drawn %0d/%0d", nd0, nd1);

    // Random sprites over random memory contents.
    for (int i = 0; i < 64; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    for (int n = 0; n < 30; n++) begin
      int rsy, rsx, rspy;
      rsy  = int'($urandom_range(0, 80));
      rspy = int'($urandom_range(0, 70));
      rsx  = int'($urandom_range(0, 246)) - 16;
      run_line(rsy, rsx, rspy, -1, -1, 0, nd0, nd1);
      $display("random %0d: sy=%0d sprx=%0d spry=%0d drawn %0d/%0d",
               n, rsy, rsx, rspy, nd0, nd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
